// File: rtl/adc_init_seq.sv
// ADC initialisation sequencer: holds the ADC in reset, writes a command table
// over the serial interface with per-command timeout/retry, then settles and flags ready.
module adc_init_seq #(
  parameter int          NCMD      = 8,
  parameter logic [15:0] PWR_DLY   = 16'd1000,
  parameter logic [7:0]  ACK_TMO   = 8'd255,
  parameter logic [1:0]  MAX_RETRY = 2'd3,
  parameter logic [15:0] SETTLE    = 16'd500
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INIT_RST,
  output logic [2:0]  TBL_ADDR,
  input  logic [23:0] TBL_DATA,
  output logic        WR_REQ,
  output logic [7:0]  WR_ADDR,
  output logic [15:0] WR_DATA,
  input  logic        WR_ACK,
  output logic        ADC_RST,
  output logic        ADC_RDY,
  output logic        INIT_ERR,
  output logic [3:0]  SEQ_STATE
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PWR_DLY = 4'd1,
    S_WRITE   = 4'd2,
    S_GAP     = 4'd3,
    S_SETTLE  = 4'd4,
    S_READY   = 4'd5,
    S_ERROR   = 4'd6
  } state_t;

  localparam logic [3:0] NCMD_C = 4'(NCMD);

  state_t      state, state_nx;
  logic [3:0]  cmd_idx, cmd_nx, cmd_inc;
  logic [1:0]  retry_cnt, retry_nx, retry_inc;
  logic [7:0]  tmo_cnt, tmo_nx, tmo_inc;
  logic [15:0] dly_cnt, dly_nx, dly_inc;

  // Every counter saturates instead of wrapping.
  assign cmd_inc   = (&cmd_idx)   ? cmd_idx   : cmd_idx + 4'd1;
  assign retry_inc = (&retry_cnt) ? retry_cnt : retry_cnt + 2'd1;
  assign tmo_inc   = (&tmo_cnt)   ? tmo_cnt   : tmo_cnt + 8'd1;
  assign dly_inc   = (&dly_cnt)   ? dly_cnt   : dly_cnt + 16'd1;

  assign SEQ_STATE = state;
  assign TBL_ADDR  = cmd_idx[2:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      cmd_idx   <= 4'd0;
      retry_cnt <= 2'd0;
      tmo_cnt   <= 8'd0;
      dly_cnt   <= 16'd0;
    end else begin
      state     <= state_nx;
      cmd_idx   <= cmd_nx;
      retry_cnt <= retry_nx;
      tmo_cnt   <= tmo_nx;
      dly_cnt   <= dly_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cmd_nx   = cmd_idx;
    retry_nx = retry_cnt;
    tmo_nx   = tmo_cnt;
    dly_nx   = dly_cnt;
    if (INIT_RST) begin
      state_nx = S_IDLE;
      cmd_nx   = 4'd0;
      retry_nx = 2'd0;
      tmo_nx   = 8'd0;
      dly_nx   = 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_PWR_DLY;
          cmd_nx   = 4'd0;
          retry_nx = 2'd0;
          tmo_nx   = 8'd0;
          dly_nx   = 16'd1;
        end
        S_PWR_DLY: begin
          if (dly_cnt >= PWR_DLY) begin
            state_nx = S_WRITE;
            cmd_nx   = 4'd0;
            tmo_nx   = 8'd1;
            dly_nx   = 16'd0;
          end else begin
            dly_nx = dly_inc;
          end
        end
        // An ack that lands on the timeout cycle still counts as an ack.
        S_WRITE: begin
          if (WR_ACK) begin
            state_nx = S_GAP;
            cmd_nx   = cmd_inc;
            retry_nx = 2'd0;
            tmo_nx   = 8'd0;
          end else if (tmo_cnt >= ACK_TMO) begin
            retry_nx = retry_inc;
            tmo_nx   = 8'd0;
            state_nx = (retry_inc >= MAX_RETRY) ? S_ERROR : S_GAP;
          end else begin
            tmo_nx = tmo_inc;
          end
        end
        S_GAP: begin
          if (cmd_idx >= NCMD_C) begin
            state_nx = S_SETTLE;
            dly_nx   = 16'd1;
          end else begin
            state_nx = S_WRITE;
            tmo_nx   = 8'd1;
          end
        end
        S_SETTLE: begin
          if (dly_cnt >= SETTLE) begin
            state_nx = S_READY;
            dly_nx   = 16'd0;
          end else begin
            dly_nx = dly_inc;
          end
        end
        S_READY, S_ERROR: state_nx = state;
        default: begin
          state_nx = S_IDLE;
          cmd_nx   = 4'd0;
          retry_nx = 2'd0;
          tmo_nx   = 8'd0;
          dly_nx   = 16'd0;
        end
      endcase
    end
  end

  // Handshake: WR_REQ stays high with WR_ADDR/WR_DATA stable until a WR_ACK
  // pulse is sampled or the attempt times out; WR_ACK is ignored otherwise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WR_REQ   <= 1'b0;
      WR_ADDR  <= 8'd0;
      WR_DATA  <= 16'd0;
      ADC_RST  <= 1'b0;
      ADC_RDY  <= 1'b0;
      INIT_ERR <= 1'b0;
    end else begin
      WR_REQ   <= (state_nx == S_WRITE);
      ADC_RST  <= (state_nx == S_PWR_DLY);
      ADC_RDY  <= (state_nx == S_READY);
      INIT_ERR <= (state_nx == S_ERROR);
      if (state_nx == S_WRITE && state != S_WRITE) begin
        WR_ADDR <= TBL_DATA[23:16];
        WR_DATA <= TBL_DATA[15:0];
      end
    end
  end

endmodule

// File: tb/tb_adc_init_seq.sv
// Bench for adc_init_seq: per-attempt ack plans expand into an expected
// cycle-by-cycle output timeline that is compared at every falling edge.
module tb_adc_init_seq;

  localparam int T_PWR    = 4;
  localparam int T_TMO    = 5;
  localparam int T_RETRY  = 2;
  localparam int T_SETTLE = 3;
  localparam int T_NCMD   = 3;

  logic        CLK = 1'b0;
  logic        RST, INIT_RST, WR_ACK;
  logic [2:0]  TBL_ADDR;
  logic [23:0] TBL_DATA;
  logic        WR_REQ, ADC_RST, ADC_RDY, INIT_ERR;
  logic [7:0]  WR_ADDR;
  logic [15:0] WR_DATA;
  logic [3:0]  SEQ_STATE;

  logic [23:0] tbl_mem [8];
  int          plan[$];
  logic [34:0] exp_q[$];
  int          drv_idx, wr_cyc, cur_k;
  int          n_chk = 0;
  int          n_fail = 0;

  assign TBL_DATA = tbl_mem[TBL_ADDR];

  adc_init_seq #(
    .NCMD(T_NCMD), .PWR_DLY(16'(T_PWR)), .ACK_TMO(8'(T_TMO)),
    .MAX_RETRY(2'(T_RETRY)), .SETTLE(16'(T_SETTLE))
  ) dut (
    .CLK(CLK), .RST(RST), .INIT_RST(INIT_RST),
    .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA),
    .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_ACK(WR_ACK),
    .ADC_RST(ADC_RST), .ADC_RDY(ADC_RDY), .INIT_ERR(INIT_ERR),
    .SEQ_STATE(SEQ_STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {state, adc_rst, wr_req, adc_rdy, init_err, tbl_addr, wr_addr, wr_data}
  function automatic logic [34:0] ev(input int st, input bit ar, input bit rq,
                                     input bit rd, input bit er, input int ta,
                                     input logic [23:0] wd);
    return {4'(st), ar, rq, rd, er, 3'(ta), wd};
  endfunction

  function automatic logic [34:0] obs_vec();
    return {SEQ_STATE, ADC_RST, WR_REQ, ADC_RDY, INIT_ERR, TBL_ADDR, WR_ADDR, WR_DATA};
  endfunction

  // Expected timeline: power delay, then per attempt a burst whose length is the
  // ack cycle (or the timeout), a gap unless retries run out, then settle/ready or error.
  task automatic build_model(input int hold);
    int cmd, rtr, p, k, len;
    bit acked, err;
    cmd = 0; rtr = 0; p = 0; err = 0;
    exp_q.delete();
    repeat (T_PWR) exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 24'd0));
    while (cmd < T_NCMD && !err) begin
      k = (p < plan.size()) ? plan[p] : 1;
      p++;
      acked = (k >= 1 && k <= T_TMO);
      len = acked ? k : T_TMO;
      repeat (len) exp_q.push_back(ev(2, 0, 1, 0, 0, cmd, tbl_mem[cmd]));
      if (acked) begin
        cmd++;
        rtr = 0;
      end else begin
        rtr++;
      end
      if (!acked && rtr == T_RETRY) err = 1;
      else exp_q.push_back(ev(3, 0, 0, 0, 0, cmd, 24'd0));
    end
    if (err) begin
      repeat (hold) exp_q.push_back(ev(6, 0, 0, 0, 1, cmd, 24'd0));
    end else begin
      repeat (T_SETTLE) exp_q.push_back(ev(4, 0, 0, 0, 0, cmd, 24'd0));
      repeat (hold) exp_q.push_back(ev(5, 0, 0, 1, 0, cmd, 24'd0));
    end
  endtask

  // Serial-interface responder: acks on the planned cycle of each burst,
  // and drives random WR_ACK noise whenever no write is requested.
  task automatic drive_ack();
    if (WR_REQ) begin
      if (wr_cyc == 0) begin
        cur_k = (drv_idx < plan.size()) ? plan[drv_idx] : 1;
        drv_idx++;
      end
      wr_cyc++;
      WR_ACK = (wr_cyc == cur_k);
    end else begin
      wr_cyc = 0;
      WR_ACK = 1'($urandom_range(0, 1));
    end
  endtask

  // hook_kind: 0 none, 1 INIT_RST abort, 2 asynchronous RST pulse
  task automatic run_seq(input string name, input int hold, input int hook_at, input int hook_kind);
    logic [34:0] e, o;
    int n;
    build_model(hold);
    drv_idx = 0; wr_cyc = 0; cur_k = 0;
    @(negedge CLK);
    o = obs_vec();
    check({name, "_idle_pre"}, 32'(o[34:24]), 32'(11'd0));
    INIT_RST = 1'b0;
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      n++;
      e = exp_q.pop_front();
      o = obs_vec();
      check($sformatf("%s_ctl%0d", name, n), 32'(o[34:24]), 32'(e[34:24]));
      if (e[29]) check($sformatf("%s_wdat%0d", name, n), 32'(o[23:0]), 32'(e[23:0]));
      drive_ack();
      if (n == hook_at) begin
        exp_q.delete();
        INIT_RST = 1'b1;
        if (hook_kind == 2) begin
          #2 RST = 1'b1;
          #1;
          o = obs_vec();
          check({name, "_async_ctl"}, 32'(o[34:24]), 32'(11'd0));
          check({name, "_async_wdat"}, 32'(o[23:0]), 32'(24'd0));
          #1 RST = 1'b0;
        end
      end
    end
    INIT_RST = 1'b1;
    WR_ACK = 1'b0;
    @(negedge CLK);
    o = obs_vec();
    check({name, "_idle_post"}, 32'(o[34:24]), 32'(11'd0));
  endtask

  initial begin
    logic [34:0] o;
    RST = 1'b1; INIT_RST = 1'b1; WR_ACK = 1'b0;
    for (int i = 0; i < 8; i++) tbl_mem[i] = 24'(32'($urandom));
    tbl_mem[0] = 24'h01_0003;
    tbl_mem[1] = 24'h02_00A5;
    tbl_mem[2] = 24'h1F_8000;
    @(negedge CLK);
    o = obs_vec();
    check("reset_ctl", 32'(o[34:24]), 32'(11'd0));
    check("reset_wdat", 32'(o[23:0]), 32'(24'd0));
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    plan = '{2, 2, 2};       run_seq("nominal", 4, 0, 0);
    plan = '{2, 0, 2, 2};    run_seq("timeout", 4, 0, 0);
    plan = '{0, 0};          run_seq("failure", 4, 0, 0);
    plan = '{0, 5, 0, 5, 5}; run_seq("collide", 4, 0, 0);
    plan = '{2, 2, 2};       run_seq("abort", 4, 11, 1);
    plan = '{2, 2, 2};       run_seq("restart", 4, 0, 0);
    plan = '{2, 2, 2};       run_seq("asyncrst", 4, 15, 2);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) tbl_mem[i] = 24'(32'($urandom));
      plan.delete();
      for (int i = 0; i < 8; i++) plan.push_back(int'($urandom_range(0, T_TMO)));
      run_seq($sformatf("rand%0d", r), 3, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
